// File: rtl/wide_add_pkg.sv
// Shared definitions for the slice-serial wide adder: FSM encoding and default geometry.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_DEFAULT     = 32;
  localparam int WORDS_DEFAULT = 4;

endpackage

// File: rtl/NbitAdder.sv
// N-bit ripple adder slice with carry in/out.
// Latency: combinational. Backpressure: none.
module NbitAdder #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);

  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, c_in};

endmodule

// File: rtl/wide_add_seq.sv
// Wide adder computed one N-bit slice per cycle through a single shared NbitAdder.
// Latency: done in cycle WORDS+1 after start; start is ignored while busy.
module wide_add_seq
  import wide_add_pkg::*;
#(
  parameter int N     = N_DEFAULT,
  parameter int WORDS = WORDS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N*WORDS-1:0]   a,
  input  logic [N*WORDS-1:0]   b,
  input  logic                 c_in,
  output logic                 busy,
  output logic                 done,
  output logic [N*WORDS-1:0]   sum,
  output logic                 c_out
);

  localparam int W  = N * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(WORDS - 1);

  state_t        state, state_nxt;
  logic [W-1:0]  a_w, b_w, work_sum, work_sum_nxt;
  logic          carry;
  logic [IW-1:0] idx;
  logic [N-1:0]  slice_sum;
  logic          slice_cout;
  logic          load, last;

  NbitAdder #(.N(N)) u_adder (
    .a     (a_w[idx*N +: N]),
    .b     (b_w[idx*N +: N]),
    .c_in  (carry),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  assign load = start && (state != RUN);
  assign last = (idx == LAST_IDX);

  always_comb begin
    work_sum_nxt = work_sum;
    work_sum_nxt[idx*N +: N] = slice_sum;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_w      <= '0;
      b_w      <= '0;
      work_sum <= '0;
      carry    <= 1'b0;
      idx      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        a_w      <= a;
        b_w      <= b;
        carry    <= c_in;
        idx      <= '0;
        work_sum <= '0;
      end else if (state == RUN) begin
        work_sum <= work_sum_nxt;
        carry    <= slice_cout;
        // Index parks on the last slice; the FSM leaves RUN on the same edge.
        if (!last) begin
          idx <= idx + IW'(1);
        end else begin
          sum   <= work_sum_nxt;
          c_out <= slice_cout;
        end
      end
    end
  end

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed vectors, multi-cycle corner sequences, random ops.
module tb_wide_add_seq;

  localparam int N     = 32;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         rst, start, c_in;
  logic [W-1:0] a, b, sum;
  logic         busy, done, c_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W:0] held;

  always #5 clk = ~clk;

  wide_add_seq #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] r;
    for (int i = 0; i < W / 32; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*32 +: 32] = '1;
        1:       r[i*32 +: 32] = '0;
        default: r[i*32 +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a clock edge; that cycle is cycle 0.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic ocin,
                       input logic [W-1:0] es, input logic ec, input string tag);
    a = oa; b = ob; c_in = ocin; start = 1'b1;
    step();
    for (int k = 1; k <= WORDS; k++) begin
      a = rand_w(); b = rand_w(); c_in = 1'($urandom_range(0, 1));
      start = (k == 2);
      @(negedge clk);
      check($sformatf("%s busy c%0d", tag, k), {{W{1'b0}}, busy}, 1);
      check($sformatf("%s done c%0d", tag, k), {{W{1'b0}}, done}, 0);
      check($sformatf("%s held c%0d", tag, k), {c_out, sum}, held);
      step();
    end
    start = 1'b0;
    @(negedge clk);
    held = {ec, es};
    check($sformatf("%s done", tag), {{W{1'b0}}, done}, 1);
    check($sformatf("%s busy at done", tag), {{W{1'b0}}, busy}, 0);
    check($sformatf("%s result", tag), {c_out, sum}, held);
    step();
    @(negedge clk);
    check($sformatf("%s done after", tag), {{W{1'b0}}, done}, 0);
    check($sformatf("%s result after", tag), {c_out, sum}, held);
    step();
  endtask

  initial begin
    logic [W-1:0] a1, b1, a2, b2;
    logic         c1, c2;
    logic [W:0]   got, exp1, exp2;
    int           ndone, dcyc;
    int           dcycs[$];
    logic [W:0]   dres[$];

    vecs[0] = '{128'd1, 128'd2, 1'b0, 128'd3, 1'b0};
    vecs[1] = '{128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0};
    vecs[2] = '{'1, '0, 1'b1, '0, 1'b1};
    vecs[3] = '{'0, '0, 1'b1, 128'd1, 1'b0};
    vecs[4] = '{'1, '1, 1'b1, '1, 1'b1};

    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    step();
    step();
    rst = 1'b0;
    held = '0;
    @(negedge clk);
    check("reset busy", {{W{1'b0}}, busy}, 0);
    check("reset done", {{W{1'b0}}, done}, 0);
    check("reset result", {c_out, sum}, 0);
    step();

    foreach (vecs[i])
      do_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
            $sformatf("vec%0d", i));

    // Start in cycle 2 lands in RUN and must be ignored.
    a = 128'd5; b = 128'd6; c_in = 1'b0; start = 1'b1;
    step();
    ndone = 0; dcyc = -1; got = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      start = (cyc == 2);
      if (cyc == 2) begin a = 128'd100; b = 128'd100; end
      @(negedge clk);
      if (done) begin ndone++; dcyc = cyc; got = {c_out, sum}; end
      step();
    end
    check("ignored start done count", W'(ndone), 1);
    check("ignored start done cycle", W'(dcyc), 5);
    check("ignored start result", got, 11);
    held = 11;

    // Reset in cycle 3 abandons the operation.
    a = 128'd9; b = 128'd9; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      rst = (cyc == 3);
      @(negedge clk);
      if (done) ndone++;
      if (cyc == 4) begin
        check("midrst busy", {{W{1'b0}}, busy}, 0);
        check("midrst result", {c_out, sum}, 0);
      end
      step();
    end
    rst = 1'b0;
    check("midrst no done", W'(ndone), 0);
    held = '0;
    do_op(128'd7, 128'd8, 1'b0, 128'd15, 1'b0, "after midrst");

    // Reset wins over a simultaneous start.
    a = 128'd3; b = 128'd4; start = 1'b1; rst = 1'b1;
    step();
    start = 1'b0; rst = 1'b0;
    ndone = 0;
    @(negedge clk);
    check("rst prio busy", {{W{1'b0}}, busy}, 0);
    check("rst prio result", {c_out, sum}, 0);
    for (int cyc = 0; cyc < 6; cyc++) begin
      step();
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("rst prio no activity", W'(ndone), 0);
    step();
    held = '0;

    // Back-to-back: restart during the DONE cycle.
    a1 = rand_w(); b1 = rand_w(); c1 = 1'($urandom_range(0, 1));
    a2 = rand_w(); b2 = rand_w(); c2 = 1'($urandom_range(0, 1));
    exp1 = model(a1, b1, c1);
    exp2 = model(a2, b2, c2);
    a = a1; b = b1; c_in = c1; start = 1'b1;
    step();
    dcycs.delete(); dres.delete();
    for (int cyc = 1; cyc <= 13; cyc++) begin
      start = (cyc == 5);
      if (cyc == 5) begin a = a2; b = b2; c_in = c2; end
      @(negedge clk);
      if (done) begin dcycs.push_back(cyc); dres.push_back({c_out, sum}); end
      step();
    end
    check("b2b done count", W'(dcycs.size()), 2);
    if (dcycs.size() == 2) begin
      check("b2b first cycle", W'(dcycs[0]), 5);
      check("b2b first result", dres[0], exp1);
      check("b2b second cycle", W'(dcycs[1]), 10);
      check("b2b second result", dres[1], exp2);
    end
    held = exp2;

    for (int t = 0; t < 30; t++) begin
      logic [W:0] e;
      a1 = rand_w(); b1 = rand_w(); c1 = 1'($urandom_range(0, 1));
      e = model(a1, b1, c1);
      do_op(a1, b1, c1, e[W-1:0], e[W], $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
